// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: BOOT/RUN/HALT control with trap, branch and
// return-address redirects. Define PC_SEQ_RAS_EN to build the return-address stack.
module pc_sequencer #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              STEP         = 4,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            fetch_valid,
   output logic [XLEN-1:0] fetch_addr,
   input  logic            fetch_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            halt_req,
   input  logic            ras_push,
   input  logic [XLEN-1:0] ras_push_addr,
   input  logic            ras_pop,
   output logic            misaligned_fault
);

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

   state_t          state_reg, state_next;
   logic            fetch_valid_reg, fetch_valid_next;
   logic [XLEN-1:0] fetch_addr_reg, fetch_addr_next;
   logic            fault_reg, fault_next;

   logic            redirect_ok, redirect_bad, handshake;
   logic            ras_hit;
   logic [XLEN-1:0] ras_top;

   assign redirect_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
   assign redirect_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
   assign handshake    = fetch_valid_reg && fetch_ready;

`ifdef PC_SEQ_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] ras_top_reg, ras_top_next, ras_wr_idx;
   logic [CNT_W-1:0] ras_cnt_reg, ras_cnt_next;
   logic             ras_wr_en, ras_nonempty;

   assign ras_nonempty = (ras_cnt_reg != '0);
   assign ras_hit      = ras_pop && ras_nonempty;
   assign ras_top      = ras_mem[ras_top_reg];

   // Stack pointer wraps circularly, so a push when full silently overwrites the oldest entry.
   always_comb begin
      ras_top_next = ras_top_reg;
      ras_cnt_next = ras_cnt_reg;
      ras_wr_en    = 1'b0;
      ras_wr_idx   = ras_top_reg;
      if (trap_valid) begin
         ras_cnt_next = '0;
      end else if (ras_push && ras_hit) begin
         ras_wr_en  = 1'b1;
         ras_wr_idx = ras_top_reg;
      end else if (ras_push) begin
         ras_top_next = ras_top_reg + 1'b1;
         ras_wr_en    = 1'b1;
         ras_wr_idx   = ras_top_reg + 1'b1;
         if (ras_cnt_reg != CNT_W'(RAS_DEPTH))
            ras_cnt_next = ras_cnt_reg + 1'b1;
      end else if (ras_hit) begin
         ras_top_next = ras_top_reg - 1'b1;
         ras_cnt_next = ras_cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ras_top_reg <= '0;
         ras_cnt_reg <= '0;
      end else begin
         ras_top_reg <= ras_top_next;
         ras_cnt_reg <= ras_cnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (ras_wr_en)
         ras_mem[ras_wr_idx] <= ras_push_addr;
   end
`else
   logic unused_ras;
   assign unused_ras = ^{ras_push, ras_pop, ras_push_addr};
   assign ras_hit    = 1'b0;
   assign ras_top    = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= ST_BOOT;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_BOOT: state_next = ST_RUN;
         ST_RUN:
            if (halt_req && (!fetch_valid_reg || fetch_ready))
               state_next = ST_HALT;
         ST_HALT:
            if (trap_valid || redirect_ok)
               state_next = ST_RUN;
         default: state_next = ST_BOOT;
      endcase
   end

   // Redirects apply in RUN and HALT; only RUN consumes RAS pops and sequential steps.
   always_comb begin
      fetch_addr_next  = fetch_addr_reg;
      fetch_valid_next = fetch_valid_reg;
      fault_next       = 1'b0;
      case (state_reg)
         ST_BOOT: fetch_valid_next = 1'b1;
         ST_RUN, ST_HALT: begin
            if (trap_valid)
               fetch_addr_next = trap_vector;
            else if (redirect_ok)
               fetch_addr_next = redirect_target;
            else if (redirect_bad)
               fault_next = 1'b1;
            else if (state_reg == ST_RUN && ras_hit)
               fetch_addr_next = ras_top;
            else if (state_reg == ST_RUN && handshake)
               fetch_addr_next = fetch_addr_reg + XLEN'(STEP);
            fetch_valid_next = (state_next == ST_RUN);
         end
         default: fetch_valid_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_valid_reg <= 1'b0;
         fetch_addr_reg  <= RESET_VECTOR;
         fault_reg       <= 1'b0;
      end else begin
         fetch_valid_reg <= fetch_valid_next;
         fetch_addr_reg  <= fetch_addr_next;
         fault_reg       <= fault_next;
      end
   end

   assign fetch_valid      = fetch_valid_reg;
   assign fetch_addr       = fetch_addr_reg;
   assign misaligned_fault = fault_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; RAS expectations follow PC_SEQ_RAS_EN.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_valid;
   logic [31:0] fetch_addr;
   logic        fetch_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_vector = '0;
   logic        halt_req = 1'b0;
   logic        ras_push = 1'b0;
   logic [31:0] ras_push_addr = '0;
   logic        ras_pop = 1'b0;
   logic        misaligned_fault;

   int vectors = 0;
   int miscompares = 0;

   pc_sequencer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fetch_valid      (fetch_valid),
      .fetch_addr       (fetch_addr),
      .fetch_ready      (fetch_ready),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .trap_valid       (trap_valid),
      .trap_vector      (trap_vector),
      .halt_req         (halt_req),
      .ras_push         (ras_push),
      .ras_push_addr    (ras_push_addr),
      .ras_pop          (ras_pop),
      .misaligned_fault (misaligned_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] a, input logic f);
      chk({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, v});
      chk({tag, ".addr"}, fetch_addr, a);
      chk({tag, ".fault"}, {31'd0, misaligned_fault}, {31'd0, f});
      $display("step %-10s valid=%0b addr=%08h fault=%0b", tag, fetch_valid, fetch_addr, misaligned_fault);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 1'b0, 32'h0, 1'b0);

      // Boot then sequential fetch
      rst_n = 1'b1;
      fetch_ready = 1'b1;
      step(); chk_out("boot", 1'b1, 32'h0, 1'b0);
      step(); chk_out("seq4", 1'b1, 32'h4, 1'b0);
      step(); chk_out("seq8", 1'b1, 32'h8, 1'b0);
      step(); chk_out("seqC", 1'b1, 32'hC, 1'b0);

      // Back to 0x8 and stall for three cycles
      fetch_ready = 1'b0;
      redirect_valid = 1'b1; redirect_target = 32'h8;
      step(); chk_out("rd8", 1'b1, 32'h8, 1'b0);
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); chk_out("stall", 1'b1, 32'h8, 1'b0);
      end
      redirect_valid = 1'b1; redirect_target = 32'h100;
      step(); chk_out("rd100", 1'b1, 32'h100, 1'b0);

      // Trap beats redirect, then misaligned target
      trap_valid = 1'b1; trap_vector = 32'h200; redirect_target = 32'h300;
      step(); chk_out("trap", 1'b1, 32'h200, 1'b0);
      trap_valid = 1'b0; redirect_target = 32'h302;
      step(); chk_out("misal", 1'b1, 32'h200, 1'b1);
      redirect_valid = 1'b0;
      step(); chk_out("misal_end", 1'b1, 32'h200, 1'b0);

      // Address wrap
      fetch_ready = 1'b1;
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      step(); chk_out("rd_top", 1'b1, 32'hFFFF_FFFC, 1'b0);
      redirect_valid = 1'b0;
      step(); chk_out("wrap", 1'b1, 32'h0, 1'b0);

      // Halt while 0x40 is accepted, misaligned redirect keeps HALT, aligned one exits
      redirect_valid = 1'b1; redirect_target = 32'h40;
      step(); chk_out("rd40", 1'b1, 32'h40, 1'b0);
      redirect_valid = 1'b0; halt_req = 1'b1;
      step(); chk_out("halt", 1'b0, 32'h44, 1'b0);
      step(); chk_out("halted", 1'b0, 32'h44, 1'b0);
      redirect_valid = 1'b1; redirect_target = 32'h82;
      step(); chk_out("halt_misal", 1'b0, 32'h44, 1'b1);
      redirect_target = 32'h80;
      step(); chk_out("resume", 1'b1, 32'h80, 1'b0);
      redirect_valid = 1'b0; halt_req = 1'b0;
      step(); chk_out("run84", 1'b1, 32'h84, 1'b0);

      // RAS: five pushes into a 4-deep stack while stalled
      fetch_ready = 1'b0;
      ras_push = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         ras_push_addr = 32'h10 * i;
         step();
      end
      chk_out("pushed", 1'b1, 32'h84, 1'b0);
      ras_push = 1'b0;

      // Five pops with fetch_ready=1
      fetch_ready = 1'b1; ras_pop = 1'b1;
`ifdef PC_SEQ_RAS_EN
      step(); chk_out("pop1", 1'b1, 32'h50, 1'b0);
      step(); chk_out("pop2", 1'b1, 32'h40, 1'b0);
      step(); chk_out("pop3", 1'b1, 32'h30, 1'b0);
      step(); chk_out("pop4", 1'b1, 32'h20, 1'b0);
      step(); chk_out("pop5", 1'b1, 32'h24, 1'b0);
`else
      step(); chk_out("pop1", 1'b1, 32'h88, 1'b0);
      step(); chk_out("pop2", 1'b1, 32'h8C, 1'b0);
      step(); chk_out("pop3", 1'b1, 32'h90, 1'b0);
      step(); chk_out("pop4", 1'b1, 32'h94, 1'b0);
      step(); chk_out("pop5", 1'b1, 32'h98, 1'b0);
`endif

      // Simultaneous push and pop while stalled
      fetch_ready = 1'b0; ras_pop = 1'b0;
      ras_push = 1'b1; ras_push_addr = 32'hA0;
      step();
      ras_pop = 1'b1; ras_push_addr = 32'hB0;
`ifdef PC_SEQ_RAS_EN
      step(); chk_out("pushpop", 1'b1, 32'hA0, 1'b0);
      ras_push = 1'b0;
      step(); chk_out("pop_new", 1'b1, 32'hB0, 1'b0);
      step(); chk_out("pop_empty", 1'b1, 32'hB0, 1'b0);
`else
      step(); chk_out("pushpop", 1'b1, 32'h98, 1'b0);
      ras_push = 1'b0;
      step(); chk_out("pop_new", 1'b1, 32'h98, 1'b0);
      step(); chk_out("pop_empty", 1'b1, 32'h98, 1'b0);
`endif
      ras_pop = 1'b0;

      // Asynchronous reset mid-operation
      #1 rst_n = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, 32'h0, 1'b0);
      step(); chk_out("rst_hold", 1'b0, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
